// File: rtl/lut4_cfg_ctrl.sv
// Run-time reconfigurable 4-input LUT: serial INIT loading over a valid/ready stream,
// atomic commit, and a registered one-lookup-per-cycle evaluation port.
module lut4_cfg_ctrl #(
   parameter logic [15:0] INIT      = 16'h9701,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cfg_start,
   input  logic       cfg_valid,
   input  logic       cfg_bit,
   output logic       cfg_ready,
   output logic       cfg_done,
   output logic       cfg_err,
   input  logic       eval_valid,
   output logic       eval_ready,
   input  logic [3:0] I,
   output logic       O,
   output logic       O_valid
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_LOAD   = 2'd1,
      ST_COMMIT = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [15:0] init_q, init_d;
   logic [15:0] shift_q, shift_d;
   logic [3:0]  count_q, count_d;
   logic        o_q, o_d;
   logic        o_valid_q, o_valid_d;
   logic        err_q, err_d;
   logic [15:0] shift_in;

   // The table only changes on the 16th accepted bit, so lookups never see a partial load.
   assign shift_in = MSB_FIRST ? {shift_q[14:0], cfg_bit} : {cfg_bit, shift_q[15:1]};

   always_comb begin
      // NOTE: every _d is given its hold/idle value first so no path leaves it unassigned (no latch).
      state_d   = state_q;
      init_d    = init_q;
      shift_d   = shift_q;
      count_d   = count_q;
      o_d       = o_q;
      o_valid_d = 1'b0;
      err_d     = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (eval_valid) begin
               o_d       = init_q[I];
               o_valid_d = 1'b1;
            end
            if (cfg_start) begin
               state_d = ST_LOAD;
               shift_d = '0;
               count_d = '0;
            end
         end
         ST_LOAD: begin
            if (cfg_start) begin
               shift_d = '0;
               count_d = '0;
               err_d   = 1'b1;
            end else if (cfg_valid) begin
               shift_d = shift_in;
               count_d = count_q + 4'd1;
               if (count_q == 4'd15) begin
                  init_d  = shift_in;
                  state_d = ST_COMMIT;
               end
            end
         end
         ST_COMMIT: state_d = ST_RUN;
         default:   state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments only, so every register sees pre-edge values of the others.
      if (!rst_n) begin
         state_q   <= ST_RUN;
         init_q    <= INIT;
         shift_q   <= '0;
         count_q   <= '0;
         o_q       <= 1'b0;
         o_valid_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         init_q    <= init_d;
         shift_q   <= shift_d;
         count_q   <= count_d;
         o_q       <= o_d;
         o_valid_q <= o_valid_d;
         err_q     <= err_d;
      end
   end

   assign cfg_ready  = (state_q == ST_LOAD);
   assign eval_ready = (state_q == ST_RUN);
   assign cfg_done   = (state_q == ST_COMMIT);
   assign cfg_err    = err_q;
   assign O          = o_q;
   assign O_valid    = o_valid_q;

endmodule

// File: tb/tb_lut4_cfg_ctrl.sv
// Self-checking bench for lut4_cfg_ctrl: a transaction-level model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_lut4_cfg_ctrl;

   localparam logic [15:0] INIT_DEF  = 16'h9701;
   localparam bit          MSB_FIRST = 1'b1;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cfg_start, cfg_valid, cfg_bit;
   logic       cfg_ready, cfg_done, cfg_err;
   logic       eval_valid, eval_ready;
   logic [3:0] lut_i;
   logic       lut_o, lut_o_valid;

   int n_checks = 0;
   int n_pass   = 0;

   lut4_cfg_ctrl #(.INIT(INIT_DEF), .MSB_FIRST(MSB_FIRST)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_start  (cfg_start),
      .cfg_valid  (cfg_valid),
      .cfg_bit    (cfg_bit),
      .cfg_ready  (cfg_ready),
      .cfg_done   (cfg_done),
      .cfg_err    (cfg_err),
      .eval_valid (eval_valid),
      .eval_ready (eval_ready),
      .I          (lut_i),
      .O          (lut_o),
      .O_valid    (lut_o_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
   endtask

   // Model: the table, the bits collected so far, and whether a commit cycle is showing.
   logic [15:0] m_table;
   bit          m_loading = 1'b0;
   bit          m_commit  = 1'b0;
   bit          m_live    = 1'b0;
   bit          m_bits[$];
   logic        e_o, e_ov, e_err;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_table   = INIT_DEF;
         m_loading = 1'b0;
         m_commit  = 1'b0;
         m_bits.delete();
         e_o       = 1'b0;
         e_ov      = 1'b0;
         e_err     = 1'b0;
         m_live    = 1'b1;
      end else if (m_live) begin
         e_ov  = 1'b0;
         e_err = 1'b0;
         if (m_commit) begin
            m_commit = 1'b0;
         end else if (!m_loading) begin
            if (eval_valid) begin
               e_o  = m_table[lut_i];
               e_ov = 1'b1;
            end
            if (cfg_start) begin
               m_loading = 1'b1;
               m_bits.delete();
            end
         end else if (cfg_start) begin
            m_bits.delete();
            e_err = 1'b1;
         end else if (cfg_valid) begin
            m_bits.push_back(cfg_bit);
            if (m_bits.size() == 16) begin
               for (int k = 0; k < 16; k++) begin
                  if (MSB_FIRST) m_table[15-k] = m_bits[k];
                  else           m_table[k]    = m_bits[k];
               end
               m_bits.delete();
               m_loading = 1'b0;
               m_commit  = 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (m_live && rst_n) begin
         check("O",          16'(lut_o),       16'(e_o));
         check("O_valid",    16'(lut_o_valid), 16'(e_ov));
         check("cfg_ready",  16'(cfg_ready),   16'(m_loading));
         check("eval_ready", 16'(eval_ready),  16'(!m_loading && !m_commit));
         check("cfg_done",   16'(cfg_done),    16'(m_commit));
         check("cfg_err",    16'(cfg_err),     16'(e_err));
      end
   end

   task automatic cyc(input logic st, input logic cv, input logic cb, input logic ev,
                      input logic [3:0] idx);
      cfg_start  = st;
      cfg_valid  = cv;
      cfg_bit    = cb;
      eval_valid = ev;
      lut_i      = idx;
      @(posedge clk);
      #1;
   endtask

   task automatic feed_bits(input logic [15:0] word, input int n, input bit gap,
                            input logic ev, input logic [3:0] idx);
      for (int k = 0; k < n; k++) begin
         if (gap) cyc(1'b0, 1'b0, 1'b0, ev, idx);
         cyc(1'b0, 1'b1, word[15-k], ev, idx);
      end
   endtask

   task automatic eval_expect(input logic [3:0] idx, input logic exp, input string name);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, idx);
      check(name, 16'(lut_o), 16'(exp));
      check({name, "_v"}, 16'(lut_o_valid), 16'd1);
   endtask

   initial begin
      rst_n = 1'b0;
      cfg_start = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0; eval_valid = 1'b0; lut_i = '0;
      repeat (3) begin @(posedge clk); #1; end
      check("rst_O",       16'(lut_o),       16'd0);
      check("rst_O_valid", 16'(lut_o_valid), 16'd0);
      check("rst_eready",  16'(eval_ready),  16'd1);
      check("rst_cready",  16'(cfg_ready),   16'd0);
      rst_n = 1'b1;

      // 1: default table, back-to-back lookups
      eval_expect(4'd12, 1'b1, "t1_I12");
      eval_expect(4'd3,  1'b0, "t1_I3");
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      check("t1_idle_ov", 16'(lut_o_valid), 16'd0);
      check("t1_hold_O",  16'(lut_o),       16'd0);

      // 2: contiguous MSB-first load of 16'h0001
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      check("t2_eready_lo", 16'(eval_ready), 16'd0);
      check("t2_cready_hi", 16'(cfg_ready),  16'd1);
      feed_bits(16'h0001, 15, 1'b0, 1'b0, 4'd0);
      check("t2_no_done_yet", 16'(cfg_done), 16'd0);
      feed_bits(16'h0001 << 15, 1, 1'b0, 1'b0, 4'd0);
      check("t2_done",       16'(cfg_done),   16'd1);
      check("t2_commit_erd", 16'(eval_ready), 16'd0);
      check("t2_model_tab",  m_table,         16'h0001);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      check("t2_done_clr",  16'(cfg_done),   16'd0);
      check("t2_eready_hi", 16'(eval_ready), 16'd1);
      eval_expect(4'd0,  1'b1, "t2_I0");
      eval_expect(4'd15, 1'b0, "t2_I15");

      // 3: gapped load of 16'hFFFF with eval_valid held high
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd5);
      check("t3_sim_ov", 16'(lut_o_valid), 16'd1);
      check("t3_sim_O",  16'(lut_o),       16'd0);
      feed_bits(16'hFFFF, 16, 1'b1, 1'b1, 4'd5);
      check("t3_done",   16'(cfg_done),    16'd1);
      check("t3_ov_lo",  16'(lut_o_valid), 16'd0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'd5);
      check("t3_no_eval_in_commit", 16'(lut_o_valid), 16'd0);
      for (int i = 0; i < 16; i++) eval_expect(4'(i), 1'b1, "t3_all_ones");

      // 4: restarts mid-stream and on the 16th bit
      rst_n = 1'b0;
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      rst_n = 1'b1;
      eval_expect(4'd8, 1'b1, "t4_default_I8");
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      feed_bits(16'hFFFF, 7, 1'b0, 1'b0, 4'd0);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
      check("t4_err",       16'(cfg_err),   16'd1);
      check("t4_err_cready", 16'(cfg_ready), 16'd1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      check("t4_err_clr",   16'(cfg_err),   16'd0);
      feed_bits(16'hFFFF, 15, 1'b0, 1'b0, 4'd0);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
      check("t4_err16",     16'(cfg_err),   16'd1);
      check("t4_nodone16",  16'(cfg_done),  16'd0);
      check("t4_table_kept", m_table,       INIT_DEF);
      feed_bits(16'h8000, 16, 1'b0, 1'b0, 4'd0);
      check("t4_done",      16'(cfg_done),  16'd1);
      check("t4_model_tab", m_table,        16'h8000);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      eval_expect(4'd15, 1'b1, "t4_I15");
      eval_expect(4'd0,  1'b0, "t4_I0");
      eval_expect(4'd8,  1'b0, "t4_I8");

      // 5: reset in the middle of a load
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      feed_bits(16'h0000, 10, 1'b0, 1'b0, 4'd0);
      rst_n = 1'b0;
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      rst_n = 1'b1;
      check("t5_eready", 16'(eval_ready), 16'd1);
      check("t5_cready", 16'(cfg_ready),  16'd0);
      check("t5_done",   16'(cfg_done),   16'd0);
      eval_expect(4'd15, 1'b1, "t5_I15");

      // 6: eval and cfg_start in the same cycle, then load 16'hA5C3
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd8);
      check("t6_O",      16'(lut_o),       16'd1);
      check("t6_ov",     16'(lut_o_valid), 16'd1);
      check("t6_eready", 16'(eval_ready),  16'd0);
      check("t6_cready", 16'(cfg_ready),   16'd1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'd8);
      check("t6_ov_lo",  16'(lut_o_valid), 16'd0);
      feed_bits(16'hA5C3, 16, 1'b0, 1'b0, 4'd0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      eval_expect(4'd0,  1'b1, "t6_I0");
      eval_expect(4'd2,  1'b0, "t6_I2");
      eval_expect(4'd14, 1'b0, "t6_I14");
      eval_expect(4'd15, 1'b1, "t6_I15");

      repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
